// File: rtl/spi_signal_bank.sv
// spi_signal_bank: SPI frame receiver feeding the signal generators.
// Shifts NUM_CH*DATA_W bits from the MCU (MSB first, framed by load) into a
// shadow register, then commits the whole frame to signal_data in one cycle
// when load falls after exactly the right number of sck rises. Short or long
// frames raise a one-cycle frame_err and leave the outputs untouched.
module spi_signal_bank #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck,
    input  logic                     sdi,
    input  logic                     load,
    output logic [NUM_CH*DATA_W-1:0] signal_data,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_count
);

    localparam int TOTAL     = NUM_CH * DATA_W;
    localparam int BIT_CNT_W = $clog2(TOTAL + 2);
    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(TOTAL);
    localparam logic [BIT_CNT_W-1:0] SAT_CNT  = BIT_CNT_W'(TOTAL + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t state;
    state_t stateNext;

    logic sckS1, sckS2, sckH;
    logic sdiS1, sdiS2, sdiH;
    logic loadS1, loadS2, loadH;

    logic sckRise;
    logic loadRise;
    logic loadFall;

    logic [1:0] settleCnt;
    logic       settled;
    logic       armed;

    logic [TOTAL-1:0]     shiftReg;
    logic [BIT_CNT_W-1:0] bitCnt;

    logic clearFrame;
    logic shiftEn;
    logic commit;
    logic reject;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sckS1  <= 1'b0;
            sckS2  <= 1'b0;
            sckH   <= 1'b0;
            sdiS1  <= 1'b0;
            sdiS2  <= 1'b0;
            sdiH   <= 1'b0;
            loadS1 <= 1'b0;
            loadS2 <= 1'b0;
            loadH  <= 1'b0;
        end else begin
            sckS1  <= sck;
            sckS2  <= sckS1;
            sckH   <= sckS2;
            sdiS1  <= sdi;
            sdiS2  <= sdiS1;
            sdiH   <= sdiS2;
            loadS1 <= load;
            loadS2 <= loadS1;
            loadH  <= loadS2;
        end
    end

    assign sckRise  = sckS2 & ~sckH;
    assign loadRise = loadS2 & ~loadH;
    assign loadFall = ~loadS2 & loadH;
    assign busy     = loadS2;

    // Frame starts are armed only once the synchronized load has been seen
    // low after reset; a load still held high across reset would otherwise
    // look like a fresh rise and end in a spurious frame_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            settleCnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (!settled) begin
                settleCnt <= settleCnt + 2'd1;
            end
            if (settled && !loadS2) begin
                armed <= 1'b1;
            end
        end
    end

    assign settled = (settleCnt == 2'd2);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and datapath strobes; an sck rise on the load-fall cycle is dropped.
    always_comb begin
        stateNext  = state;
        clearFrame = 1'b0;
        shiftEn    = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (loadRise && armed) begin
                    stateNext  = RECV;
                    clearFrame = 1'b1;
                end
            end
            RECV: begin
                if (loadFall) begin
                    stateNext = IDLE;
                    if (bitCnt == FULL_CNT) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (sckRise) begin
                    shiftEn = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Shift register, saturating bit counter, atomic commit and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg    <= '0;
            bitCnt      <= '0;
            signal_data <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= commit;
            frame_err   <= reject;
            if (clearFrame) begin
                shiftReg <= '0;
                bitCnt   <= '0;
            end else if (shiftEn) begin
                shiftReg <= {shiftReg[TOTAL-2:0], sdiS2};
                if (bitCnt != SAT_CNT) begin
                    bitCnt <= bitCnt + BIT_CNT_W'(1);
                end
            end
            if (commit) begin
                signal_data <= shiftReg;
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_signal_bank.sv
// Bench for spi_signal_bank: directed SPI frames into a default 6x8 instance
// and a 4x12 instance with a 2-bit frame counter. Expected pulses are queued
// when load drops and checked by a monitor when frame_valid/frame_err fire.
module tb_spi_signal_bank;

    typedef struct {
        logic        isErr;
        logic [47:0] data;
        logic [15:0] count;
        int unsigned cyc;
    } evt_t;

    logic clk;
    logic rst;
    logic sckP [2];
    logic sdiP [2];
    logic loadP[2];

    logic [47:0] data0, data1;
    logic        valid0, valid1, err0, err1, busy0, busy1;
    logic [15:0] cnt0;
    logic [1:0]  fc1;
    logic [15:0] cnt1;

    evt_t q0[$];
    evt_t q1[$];

    logic [47:0] mData [2];
    logic [15:0] mCount[2];

    int unsigned cyc;
    int          assertions;
    int          failures;

    spi_signal_bank dut0 (
        .clk(clk), .reset(rst), .sck(sckP[0]), .sdi(sdiP[0]), .load(loadP[0]),
        .signal_data(data0), .frame_valid(valid0), .frame_err(err0),
        .busy(busy0), .frame_count(cnt0)
    );

    spi_signal_bank #(.NUM_CH(4), .DATA_W(12), .CNT_W(2)) dut1 (
        .clk(clk), .reset(rst), .sck(sckP[1]), .sdi(sdiP[1]), .load(loadP[1]),
        .signal_data(data1), .frame_valid(valid1), .frame_err(err1),
        .busy(busy1), .frame_count(fc1)
    );

    assign cnt1 = {14'b0, fc1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic monitorDut(input int d, input logic v, input logic e,
                              input logic [47:0] data, input logic [15:0] cnt);
        evt_t x;
        int   qs;
        if (v || e) begin
            qs = (d == 0) ? q0.size() : q1.size();
            chk("pulse_expected", d, 64'(qs != 0), 64'd1);
            if (qs != 0) begin
                if (d == 0) x = q0.pop_front();
                else        x = q1.pop_front();
                chk("pulse_kind", d, {62'b0, v, e}, x.isErr ? 64'b01 : 64'b10);
                chk("pulse_latency", d, 64'(cyc), 64'(x.cyc + 3));
                chk("signal_data", d, 64'(data), 64'(x.data));
                chk("frame_count", d, 64'(cnt), 64'(x.count));
            end
        end
    endtask

    // Monitor: every output pulse must match the head of that DUT's queue.
    always @(negedge clk) begin
        monitorDut(0, valid0, err0, data0, cnt0);
        monitorDut(1, valid1, err1, data1, cnt1);
    end

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBits(input int d, input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdiP[d] = v[i];
            waitCyc(4);
            sckP[d] = 1'b1;
            waitCyc(4);
            sckP[d] = 1'b0;
        end
    endtask

    task automatic startFrame(input int d);
        loadP[d] = 1'b1;
        waitCyc(4);
    endtask

    // kind: 0 = commit expected, 1 = rejection expected, 2 = no pulse expected
    task automatic endFrame(input int d, input int kind, input logic [47:0] frame);
        evt_t x;
        logic [15:0] mask;
        mask = (d == 0) ? 16'hFFFF : 16'h0003;
        waitCyc(4);
        loadP[d] = 1'b0;
        if (kind != 2) begin
            if (kind == 0) begin
                mData[d]  = frame;
                mCount[d] = (mCount[d] + 16'd1) & mask;
            end
            x.isErr = (kind == 1);
            x.data  = mData[d];
            x.count = mCount[d];
            x.cyc   = cyc;
            if (d == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
        waitCyc(8);
    endtask

    task automatic fullFrame(input int d, input logic [47:0] frame);
        startFrame(d);
        sendBits(d, 64'(frame), 48);
        endFrame(d, 0, frame);
    endtask

    task automatic doReset();
        rst = 1'b1;
        waitCyc(3);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mData[d]  = '0;
            mCount[d] = '0;
        end
    endtask

    logic [47:0] exp48;

    initial begin
        cyc        = 0;
        assertions = 0;
        failures   = 0;
        rst        = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sckP[d]   = 1'b0;
            sdiP[d]   = 1'b0;
            loadP[d]  = 1'b0;
            mData[d]  = '0;
            mCount[d] = '0;
        end
        waitCyc(1);
        doReset();

        // Reset state
        chk("rst_data", 0, 64'(data0), 64'd0);
        chk("rst_count", 0, 64'(cnt0), 64'd0);
        chk("rst_valid", 0, 64'(valid0), 64'd0);
        chk("rst_err", 0, 64'(err0), 64'd0);
        chk("rst_busy", 0, 64'(busy0), 64'd0);
        chk("rst_data", 1, 64'(data1), 64'd0);
        chk("rst_count", 1, 64'(cnt1), 64'd0);
        chk("rst_busy", 1, 64'(busy1), 64'd0);
        waitCyc(4);

        // 1: good frame
        startFrame(0);
        chk("busy_in_frame", 0, 64'(busy0), 64'd1);
        sendBits(0, 64'h5566778899AA, 48);
        endFrame(0, 0, 48'h5566778899AA);
        exp48 = 48'h5566778899AA;
        for (int c = 0; c < 6; c++) begin
            chk("t1_channel", 0, 64'(data0[47 - 8*c -: 8]), 64'(exp48[47 - 8*c -: 8]));
        end
        chk("t1_busy_after", 0, 64'(busy0), 64'd0);

        // 2: short frame of 40 bits
        startFrame(0);
        sendBits(0, 64'h1122334455, 40);
        endFrame(0, 1, '0);
        chk("t2_data_held", 0, 64'(data0), 64'h5566778899AA);
        chk("t2_count_held", 0, 64'(cnt0), 64'd1);

        // 3: long frame of 49 bits
        startFrame(0);
        sendBits(0, 64'h1_2345_6789_ABCD, 49);
        endFrame(0, 1, '0);
        chk("t3_data_held", 0, 64'(data0), 64'h5566778899AA);
        chk("t3_count_held", 0, 64'(cnt0), 64'd1);

        // 4: sck activity with load low is ignored, then a good frame
        for (int i = 0; i < 10; i++) begin
            sdiP[0] = i[0];
            sckP[0] = 1'b1;
            waitCyc(4);
            sckP[0] = 1'b0;
            waitCyc(4);
        end
        chk("t4_idle_data", 0, 64'(data0), 64'h5566778899AA);
        fullFrame(0, 48'h0102030405FF);
        exp48 = 48'h0102030405FF;
        for (int c = 0; c < 6; c++) begin
            chk("t4_channel", 0, 64'(data0[47 - 8*c -: 8]), 64'(exp48[47 - 8*c -: 8]));
        end
        chk("t4_count", 0, 64'(cnt0), 64'd2);

        // 5: reset after 20 bits, finish the frame, no pulse; then a good frame
        exp48 = 48'hDEADBEEFCAFE;
        startFrame(0);
        sendBits(0, 64'(exp48[47:28]), 20);
        doReset();
        sendBits(0, 64'(exp48[27:0]), 28);
        endFrame(0, 2, '0);
        chk("t5_data_zero", 0, 64'(data0), 64'd0);
        chk("t5_count_zero", 0, 64'(cnt0), 64'd0);
        chk("t5_busy_zero", 0, 64'(busy0), 64'd0);
        fullFrame(0, 48'h13579BDF2468);
        chk("t5_recover_data", 0, 64'(data0), 64'h13579BDF2468);
        chk("t5_recover_count", 0, 64'(cnt0), 64'd1);

        // 6: 4x12 instance, 2-bit counter wraps after four commits
        for (int f = 0; f < 5; f++) begin
            fullFrame(1, 48'hABC123456789);
        end
        chk("t6_ch0", 1, 64'(data1[47:36]), 64'hABC);
        chk("t6_ch1", 1, 64'(data1[35:24]), 64'h123);
        chk("t6_ch2", 1, 64'(data1[23:12]), 64'h456);
        chk("t6_ch3", 1, 64'(data1[11:0]), 64'h789);
        chk("t6_count_wrap", 1, 64'(cnt1), 64'd1);
        chk("t6_dut0_untouched", 0, 64'(cnt0), 64'd1);

        waitCyc(10);
        chk("sb_drain", 0, 64'(q0.size()), 64'd0);
        chk("sb_drain", 1, 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
